// File: rtl/encoder_8to3_hs.sv
// Sticky 8-line request collector that presents one pending request at a time
// as a 3-bit index on a valid/ready handshake (fixed priority or round-robin).
module encoder_8to3_hs #(
  parameter bit RR_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic       clear_in,
  output logic [2:0] enc_out,
  output logic       enc_valid,
  input  logic       enc_ready,
  output logic [7:0] pending,
  output logic       coalesce
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] enc_q, enc_d;
  logic [7:0] pending_q, pending_d;
  logic       coalesce_q, coalesce_d;
  logic [2:0] ptr_q, ptr_d;
  logic       accept_s;
  logic [7:0] clr_s;

  // First set bit of vec scanning ptr, ptr+1, ... with 3-bit wrap.
  function automatic logic [2:0] select_idx(input logic [7:0] vec, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    select_idx = 3'd0;
    found      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && vec[idx]) begin
        select_idx = idx;
        found      = 1'b1;
      end
    end
  endfunction

  // Handshake, pending-set update and next presented index.
  always_comb begin
    accept_s   = (state_q == ST_HOLD) && enc_ready;
    clr_s      = accept_s ? (8'd1 << enc_q) : 8'd0;
    pending_d  = (pending_q & ~clr_s) | req_in;
    coalesce_d = |(req_in & pending_q & ~clr_s);
    ptr_d      = ptr_q;
    if (RR_EN && accept_s) begin
      ptr_d = enc_q + 3'd1;
    end else begin
      ptr_d = ptr_q;
    end
    state_d = state_q;
    enc_d   = enc_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_d != 8'd0) begin
          state_d = ST_HOLD;
          enc_d   = select_idx(pending_d, RR_EN ? ptr_d : 3'd0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (accept_s && (pending_d != 8'd0)) begin
          state_d = ST_HOLD;
          enc_d   = select_idx(pending_d, RR_EN ? ptr_d : 3'd0);
        end else if (accept_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        enc_d   = 3'd0;
      end
    endcase
  end

  // State registers; reset beats clear, and clear keeps the round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      enc_q      <= 3'd0;
      pending_q  <= 8'd0;
      coalesce_q <= 1'b0;
      ptr_q      <= 3'd0;
    end else if (clear_in) begin
      state_q    <= ST_IDLE;
      enc_q      <= 3'd0;
      pending_q  <= 8'd0;
      coalesce_q <= 1'b0;
      ptr_q      <= ptr_q;
    end else begin
      state_q    <= state_d;
      enc_q      <= enc_d;
      pending_q  <= pending_d;
      coalesce_q <= coalesce_d;
      ptr_q      <= ptr_d;
    end
  end

  assign enc_out   = enc_q;
  assign enc_valid = state_q;
  assign pending   = pending_q;
  assign coalesce  = coalesce_q;

endmodule

// File: tb/tb_encoder_8to3_hs.sv
// Directed bench: fixed-priority and round-robin instances share stimulus,
// every expectation hand-computed.
module tb_encoder_8to3_hs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic       clear_in;
  logic       enc_ready;
  logic [2:0] fp_enc, rr_enc;
  logic       fp_valid, rr_valid;
  logic [7:0] fp_pend, rr_pend;
  logic       fp_coal, rr_coal;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  encoder_8to3_hs #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clear_in(clear_in),
    .enc_out(fp_enc), .enc_valid(fp_valid), .enc_ready(enc_ready),
    .pending(fp_pend), .coalesce(fp_coal)
  );

  encoder_8to3_hs #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clear_in(clear_in),
    .enc_out(rr_enc), .enc_valid(rr_valid), .enc_ready(enc_ready),
    .pending(rr_pend), .coalesce(rr_coal)
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks both instances against the same expected outputs.
  task automatic check_both(input string tag, input logic [2:0] enc, input logic valid,
                            input logic [7:0] pend, input logic coal);
    check_val({tag, " fp enc"},   {5'd0, fp_enc},  {5'd0, enc});
    check_val({tag, " fp valid"}, {7'd0, fp_valid}, {7'd0, valid});
    check_val({tag, " fp pend"},  fp_pend,          pend);
    check_val({tag, " fp coal"},  {7'd0, fp_coal},  {7'd0, coal});
    check_val({tag, " rr enc"},   {5'd0, rr_enc},  {5'd0, enc});
    check_val({tag, " rr valid"}, {7'd0, rr_valid}, {7'd0, valid});
    check_val({tag, " rr pend"},  rr_pend,          pend);
    check_val({tag, " rr coal"},  {7'd0, rr_coal},  {7'd0, coal});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_in = 8'h00; clear_in = 1'b0; enc_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_in = 8'hFF; clear_in = 1'b0; enc_ready = 1'b1;
    #2;
    // 1 reset with all requests high
    tick(); tick();
    check_both("reset", 3'd0, 1'b0, 8'h00, 1'b0);

    // 2 fixed priority drain 2,5,7
    rst_n = 1'b1; req_in = 8'hA4; enc_ready = 1'b1;
    tick();
    check_both("drain0", 3'd2, 1'b1, 8'hA4, 1'b0);
    req_in = 8'h00;
    tick();
    check_both("drain1", 3'd5, 1'b1, 8'hA0, 1'b0);
    tick();
    check_both("drain2", 3'd7, 1'b1, 8'h80, 1'b0);
    tick();
    check_both("drain3", 3'd7, 1'b0, 8'h00, 1'b0);

    // 3 stall holds index, late request queued behind it
    do_reset();
    req_in = 8'h08; enc_ready = 1'b0;
    tick();
    check_both("stall0", 3'd3, 1'b1, 8'h08, 1'b0);
    req_in = 8'h00;
    tick();
    req_in = 8'h01;
    tick();
    check_both("stall2", 3'd3, 1'b1, 8'h09, 1'b0);
    req_in = 8'h00;
    tick(); tick();
    check_both("stall4", 3'd3, 1'b1, 8'h09, 1'b0);
    enc_ready = 1'b1;
    tick();
    check_both("stall_acc3", 3'd0, 1'b1, 8'h01, 1'b0);
    tick();
    check_both("stall_acc0", 3'd0, 1'b0, 8'h00, 1'b0);

    // 4 round-robin walks all indices with wrap; fixed priority sticks at 0
    do_reset();
    req_in = 8'hFF; enc_ready = 1'b1;
    tick();
    check_val("rr0 enc", {5'd0, rr_enc}, 8'd0);
    check_val("fp0 enc", {5'd0, fp_enc}, 8'd0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_val("rr walk enc", {5'd0, rr_enc}, 8'(i % 8));
      check_val("fp walk enc", {5'd0, fp_enc}, 8'd0);
      check_val("rr walk valid", {7'd0, rr_valid}, 8'd1);
    end

    // 5 re-arm in accept cycle vs coalesce without accept
    do_reset();
    req_in = 8'h10; enc_ready = 1'b0;
    tick();
    check_both("rearm0", 3'd4, 1'b1, 8'h10, 1'b0);
    enc_ready = 1'b1;
    tick();
    check_both("rearm_acc", 3'd4, 1'b1, 8'h10, 1'b0);
    enc_ready = 1'b0;
    tick();
    check_both("coal_on", 3'd4, 1'b1, 8'h10, 1'b1);
    req_in = 8'h00;
    tick();
    check_both("coal_off", 3'd4, 1'b1, 8'h10, 1'b0);

    // 6 clear then reset mid-transaction, same-cycle requests discarded
    do_reset();
    req_in = 8'h66; enc_ready = 1'b0;
    tick();
    check_both("flush_pre", 3'd1, 1'b1, 8'h66, 1'b0);
    clear_in = 1'b1; req_in = 8'hFF;
    tick();
    check_both("flush", 3'd0, 1'b0, 8'h00, 1'b0);
    clear_in = 1'b0; req_in = 8'h66;
    tick();
    check_both("rst_pre", 3'd1, 1'b1, 8'h66, 1'b0);
    rst_n = 1'b0; clear_in = 1'b1; req_in = 8'hFF;
    tick();
    check_both("rst_clr", 3'd0, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
